cla16_pipe: RTL
===============

# cla16_pipe

- Pipelined 16-bit carry-lookahead adder/subtractor built on the team's 4-bit group generate/propagate block (`gp4`).
- Sits between the operand-issue logic and the result consumer.
- Accepts one operand pair per cycle under a valid/ready handshake.
- Produces the sum, carry-out and signed overflow after a fixed two-cycle pipeline delay, with full backpressure.

## Interface

Parameters:
- none. Widths come from `cla_pkg`: `WIDTH` = 16, `GRP` = 4, `NGRP` = 4.

Ports:
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `in_valid`  input  1  — operand pair presented.
- `in_ready`  output  1  — block can accept this cycle.
- `in_a`  input  16  — operand A.
- `in_b`  input  16  — operand B.
- `in_cin`  input  1  — carry-in. Ignored when `in_sub` = 1.
- `in_sub`  input  1  — 1 selects A − B.
- `out_valid`  output  1  — result held.
- `out_ready`  input  1  — consumer takes the result.
- `out_sum`  output  16  — result.
- `out_cout`  output  1  — carry out of bit 15. For subtract this is the not-borrow flag.
- `out_ovf`  output  1  — two's-complement overflow.

## Operation

- Effective operands:
  - B′ = `in_sub` ? ~`in_b` : `in_b`.
  - c0 = `in_sub` ? 1 : `in_cin`.
- Stage S1 is registered on acceptance. It holds A, B′, c0 and valid.
- Between S1 and S2 (combinational):
  - Per-bit g = a & b′, p = a | b′, x = a ^ b′.
  - Four `gp4` instances produce group G[3:0] and P[3:0].
- Stage S2 registers g, p, x, G, P, c0, A[15], B′[15] and valid.
- Between S2 and OUT (combinational):
  - A level-2 `gp4` (gin = G, pin = P, cin = c0) gives group carries C4, C8, C12 and C16.
  - Four `gp4` instances, each fed its group carry-in (c0, C4, C8, C12), give the internal bit carries.
  - sum[i] = x[i] ^ carry-in[i].
- OUT register holds:
  - `out_sum` — the sum.
  - `out_cout` = C16.
  - `out_ovf` = (A[15] == B′[15]) && (sum[15] != A[15]).
- Advance enable: adv = !`out_valid` || `out_ready`.
  - When adv = 1, all three registers shift together; a bubble (valid = 0) shifts like data.
  - When adv = 0, all stages hold.
- `in_ready` = adv. This is combinational from `out_ready`; there are no other internal paths from inputs to outputs.
- Acceptance happens when `in_valid` && `in_ready`. When `in_valid` = 0 and adv = 1, a bubble enters S1.
- Result order equals acceptance order. No result is dropped or duplicated.
- `out_sum`, `out_cout` and `out_ovf` are stable while `out_valid` && !`out_ready`.

## Timing

- Reset value of every register is 0, so `out_valid` = 0, `out_sum` = 0, `out_cout` = 0, `out_ovf` = 0.
  - `in_ready` = 1 during and after reset.
- Reset asserted mid-stream clears all stage valids immediately (asynchronously). In-flight operations are discarded, not completed.
- Latency: a pair accepted at rising edge N gives `out_valid` = 1 after edge N+2, provided adv = 1 at edges N+1 and N+2. Each stalled cycle adds one cycle.
- Throughput is one result per cycle with `out_ready` held at 1.
- Result accepted and new input accepted in the same cycle is legal. The pipeline shifts and no bubble is inserted.
- `out_ready` = 0 with `out_valid` = 0 does not stall (adv = 1).
- Critical path: S2 → level-2 `gp4` → group `gp4` → XOR → OUT. No ripple across groups.

## Structure

- `cla_pkg` contains:
  - `WIDTH`, `GRP` and `NGRP` localparams.
  - `typedef logic [WIDTH-1:0] word_t`.
  - `typedef logic [NGRP-1:0] grp_t`.
  - Packed struct `s1_t` {a, b, c0, v}.
  - Packed struct `s2_t` {g, p, x, G, P, c0, a15, b15, v}.
- Sub-module: reuse the existing `gp4` unchanged, 9 instances.
  - 4 in the S1→S2 logic, taking `gout`/`pout` only, with cin tied 0.
  - 5 in the S2→OUT logic, taking `cout`.
- No other sub-modules. Stage registers are inline `always_ff` with async reset.

## Test plan

- 0xFFFF + 0x0001, cin 0, add → `out_sum` 0x0000, `out_cout` 1, `out_ovf` 0, exactly 2 cycles after acceptance.
- 0x7FFF + 0x0001, add → 0x8000, `out_cout` 0, `out_ovf` 1. Then 0x0FFF + 0x0001 → 0x1000 (group-carry chain).
- Subtract 0x0005 − 0x0007 → 0xFFFE, `out_cout` 0. Then 0x8000 − 0x0001 → 0x7FFF, `out_ovf` 1. `in_cin` = 1 must have no effect.
- Stream 8 back-to-back pairs with `out_ready` = 1 → 8 consecutive valid results in order, `in_ready` constantly 1.
- Stream with `out_ready` held 0 for 3 cycles while `out_valid` = 1:
  - `in_ready` = 0 and outputs hold steady.
  - No loss or duplication after release.
  - Check every result against a reference model.
- Assert `rst_n` low for 1 cycle with 2 operations in flight → `out_valid` 0 immediately, no stale result afterwards, next accepted pair emerges with normal latency.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg
// Shared widths and pipeline stage records for the pipelined 16-bit
// carry-lookahead adder/subtractor (cla16_pipe).
//   WIDTH  - datapath width in bits
//   GRP    - bits per lookahead group (one gp4 block)
//   NGRP   - number of groups across the word
//   s1_t   - first stage: effective operands, carry-in, valid
//   s2_t   - second stage: per-bit g/p/x, group G/P, carry-in,
//            operand sign bits for overflow, valid
package cla_pkg;

    localparam int WIDTH = 16;
    localparam int GRP   = 4;
    localparam int NGRP  = WIDTH / GRP;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [NGRP-1:0]  grp_t;

    typedef struct packed {
        word_t a;
        word_t b;
        logic  c0;
        logic  v;
    } s1_t;

    typedef struct packed {
        word_t g;
        word_t p;
        word_t x;
        grp_t  G;
        grp_t  P;
        logic  c0;
        logic  a15;
        logic  b15;
        logic  v;
    } s2_t;

endpackage

// File: rtl/gp4.sv
// gp4
// Four-bit carry-lookahead block. Every carry is a flat sum-of-products
// of the generate/propagate inputs and the carry-in, so no carry ripples
// through the block.
//   gin[3:0]  - per-position generate
//   pin[3:0]  - per-position propagate
//   cin       - carry into position 0
//   gout      - group generate
//   pout      - group propagate
//   cout[3:0] - carry out of position i (cout[3] is the group carry-out)
module gp4 (
    input  logic [3:0] gin,
    input  logic [3:0] pin,
    input  logic       cin,
    output logic       gout,
    output logic       pout,
    output logic [3:0] cout
);

    // Expanded lookahead equations for the carries out of each position.
    always_comb begin
        cout[0] = gin[0] | (pin[0] & cin);
        cout[1] = gin[1] | (pin[1] & gin[0]) | (pin[1] & pin[0] & cin);
        cout[2] = gin[2] | (pin[2] & gin[1]) | (pin[2] & pin[1] & gin[0])
                | (pin[2] & pin[1] & pin[0] & cin);
        cout[3] = gin[3] | (pin[3] & gin[2]) | (pin[3] & pin[2] & gin[1])
                | (pin[3] & pin[2] & pin[1] & gin[0])
                | (pin[3] & pin[2] & pin[1] & pin[0] & cin);
    end

    // Group terms let a higher-level gp4 compute carries across groups.
    always_comb begin
        gout = gin[3] | (pin[3] & gin[2]) | (pin[3] & pin[2] & gin[1])
             | (pin[3] & pin[2] & pin[1] & gin[0]);
        pout = &pin;
    end

endmodule

// File: rtl/cla16_pipe.sv
// cla16_pipe
// Two-stage pipelined 16-bit carry-lookahead adder/subtractor with a
// valid/ready handshake on both sides and full backpressure.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - operand handshake (in_ready = advance enable)
//   in_a, in_b           - operands
//   in_cin               - carry-in for add (ignored when subtracting)
//   in_sub               - 1 selects A - B
//   out_valid/out_ready  - result handshake
//   out_sum              - 16-bit result
//   out_cout             - carry out of bit 15 (not-borrow for subtract)
//   out_ovf              - two's-complement overflow
module cla16_pipe
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    s1_t   s1_d, s1_q;
    s2_t   s2_d, s2_q;
    logic  adv;

    logic  outValid_q;
    word_t outSum_q, outSum_d;
    logic  outCout_q, outCout_d;
    logic  outOvf_q, outOvf_d;

    word_t bitG, bitP;
    grp_t  grpG, grpP;
    grp_t  grpCarry;
    grp_t  grpCin;
    word_t s2Cout;
    word_t bitCin;

    word_t unusedS1Cout;
    grp_t  unusedS2Gout, unusedS2Pout;
    logic  unusedLvl2Gout, unusedLvl2Pout;
    grp_t  unusedGrpTopCarry;

    // The whole pipeline moves as one unit: it advances whenever the
    // output slot is empty or being drained this cycle.
    assign adv      = !outValid_q || out_ready;
    assign in_ready = adv;

    // Subtraction is A + ~B + 1, so the inversion and forced carry-in are
    // folded into the operands before they are registered.
    always_comb begin
        s1_d    = '0;
        s1_d.a  = in_a;
        s1_d.b  = in_sub ? ~in_b : in_b;
        s1_d.c0 = in_sub ? 1'b1 : in_cin;
        s1_d.v  = in_valid;
    end

    // First-level group generate/propagate. Only the group terms are
    // needed here; the carries are recomputed next stage once c0 is known
    // to the group blocks.
    assign bitG = s1_q.a & s1_q.b;
    assign bitP = s1_q.a | s1_q.b;

    for (genvar k = 0; k < NGRP; k++) begin : gGrpS1
        gp4 uGp4S1 (
            .gin  (bitG[k*GRP +: GRP]),
            .pin  (bitP[k*GRP +: GRP]),
            .cin  (1'b0),
            .gout (grpG[k]),
            .pout (grpP[k]),
            .cout (unusedS1Cout[k*GRP +: GRP])
        );
    end

    // Capture everything the carry/sum stage needs, including the sign
    // bits of the effective operands for overflow detection.
    always_comb begin
        s2_d     = '0;
        s2_d.g   = bitG;
        s2_d.p   = bitP;
        s2_d.x   = s1_q.a ^ s1_q.b;
        s2_d.G   = grpG;
        s2_d.P   = grpP;
        s2_d.c0  = s1_q.c0;
        s2_d.a15 = s1_q.a[WIDTH-1];
        s2_d.b15 = s1_q.b[WIDTH-1];
        s2_d.v   = s1_q.v;
    end

    // Level-2 lookahead over the group terms yields C4, C8, C12, C16 in
    // parallel, so no carry ripples between groups.
    gp4 uGp4Lvl2 (
        .gin  (s2_q.G),
        .pin  (s2_q.P),
        .cin  (s2_q.c0),
        .gout (unusedLvl2Gout),
        .pout (unusedLvl2Pout),
        .cout (grpCarry)
    );

    assign grpCin = {grpCarry[NGRP-2:0], s2_q.c0};

    // Each group block turns its group carry-in into the carry into every
    // bit position. The group's own top carry duplicates the level-2 one.
    for (genvar k = 0; k < NGRP; k++) begin : gGrpS2
        gp4 uGp4S2 (
            .gin  (s2_q.g[k*GRP +: GRP]),
            .pin  (s2_q.p[k*GRP +: GRP]),
            .cin  (grpCin[k]),
            .gout (unusedS2Gout[k]),
            .pout (unusedS2Pout[k]),
            .cout (s2Cout[k*GRP +: GRP])
        );
        assign bitCin[k*GRP]              = grpCin[k];
        assign bitCin[k*GRP+1 +: GRP-1]   = s2Cout[k*GRP +: GRP-1];
        assign unusedGrpTopCarry[k]       = s2Cout[k*GRP+GRP-1];
    end

    // Final sum and flags. Overflow: both effective operands share a sign
    // and the result sign differs from it.
    always_comb begin
        outSum_d  = s2_q.x ^ bitCin;
        outCout_d = grpCarry[NGRP-1];
        outOvf_d  = (s2_q.a15 == s2_q.b15) && (outSum_d[WIDTH-1] != s2_q.a15);
    end

    // All three stages shift together on advance; bubbles shift like data.
    // Reset clears every stage so in-flight work is discarded at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            outValid_q <= 1'b0;
            outSum_q   <= '0;
            outCout_q  <= 1'b0;
            outOvf_q   <= 1'b0;
        end else if (adv) begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            outValid_q <= s2_q.v;
            outSum_q   <= outSum_d;
            outCout_q  <= outCout_d;
            outOvf_q   <= outOvf_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_sum   = outSum_q;
    assign out_cout  = outCout_q;
    assign out_ovf   = outOvf_q;

endmodule
